spi_slave: RTL and testbench

Oversampled SPI responder (mode 0, MSB first) for the SPI interface block; the counterpart of the team's SPI master. It samples the external SCLK, SS_N and MOSI pins on the system clock through synchronizers and shifts received bits into a word register. It drives MISO from a one-word transmit holding buffer, and hands complete received words to the core with a one-cycle valid pulse. Supports back-to-back words within one SS_N assertion.

---
 rtl/spi_pkg.sv | 19 +
 rtl/spi_slave_if.sv | 28 ++
 rtl/spi_sync.sv | 44 ++++
 rtl/spi_slave.sv | 173 +++++++++++++++++
 tb/tb_spi_slave.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: responder state encoding and the bus mode constants
// common to the SPI master and slave.
package spi_pkg;

  localparam logic [1:0] WAIT_IDLE = 2'd0;
  localparam logic [1:0] IDLE      = 2'd1;
  localparam logic [1:0] ACTIVE    = 2'd2;

  typedef enum logic [1:0] {
    StWaitIdle = WAIT_IDLE,
    StIdle     = IDLE,
    StActive   = ACTIVE
  } spi_state_e;

  localparam bit CPOL      = 1'b0;
  localparam bit CPHA      = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/spi_slave_if.sv
// SPI pin and core-side handshake bundle for the SPI responder.
interface spi_slave_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             sclk;
  logic             ss_n;
  logic             mosi;
  logic             miso;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             tx_underrun;
  logic             busy;

  modport slave (
    input  sclk, ss_n, mosi, tx_data, tx_valid,
    output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output sclk, ss_n, mosi, tx_data, tx_valid,
    input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface

// File: rtl/spi_sync.sv
// Pin synchronizer: SYNC_STAGES flop chain followed by a registered edge detector.
// o_level is aligned with the o_rise/o_fall pulses.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          RESET_VAL   = 1'b0
) (
  input  logic i_clk,
  input  logic i_clr_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_ready
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES:0]   r_fill;
  logic                   r_prev;
  logic                   r_rise;
  logic                   r_fall;

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_fill <= '0;
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      // Tracks when every stage holds a real pin sample rather than the reset value.
      r_fill <= {r_fill[SYNC_STAGES-1:0], 1'b1};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
      r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
    end
  end

  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;
  assign o_ready = r_fill[SYNC_STAGES];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples the SPI pins on the system clock, receives
// MSB-first words and serves MISO from a one-word transmit holding buffer.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_clr_n,
  spi_slave_if.slave io_spi
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic w_sclk_level, w_sclk_rise, w_sclk_fall, w_sclk_ready;
  logic w_ss_level, w_ss_rise, w_ss_fall, w_ss_ready;
  logic w_mosi_level, w_mosi_rise, w_mosi_fall, w_mosi_ready;
  logic w_unused;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .i_clk   (i_clk),
    .i_clr_n (i_clr_n),
    .i_pin   (io_spi.sclk),
    .o_level (w_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall),
    .o_ready (w_sclk_ready)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .i_clk   (i_clk),
    .i_clr_n (i_clr_n),
    .i_pin   (io_spi.ss_n),
    .o_level (w_ss_level),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall),
    .o_ready (w_ss_ready)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .i_clk   (i_clk),
    .i_clr_n (i_clr_n),
    .i_pin   (io_spi.mosi),
    .o_level (w_mosi_level),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall),
    .o_ready (w_mosi_ready)
  );

  assign w_unused = ^{w_sclk_level, w_sclk_ready, w_mosi_rise, w_mosi_fall, w_mosi_ready};

  spi_state_e       r_state;
  logic [WIDTH-1:0] r_shift_in;
  logic [WIDTH-1:0] r_shift_out;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_rx_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full;
  logic             r_skip_fall;
  logic             r_rx_valid;
  logic             r_underrun;
  logic             r_busy;

  logic             w_abort;
  logic             w_active;
  logic             w_enter;
  logic             w_word_done;
  logic             w_load;
  logic             w_tx_accept;
  logic [WIDTH-1:0] w_shift_in_next;

  assign w_abort         = (r_state == StActive) && w_ss_rise;
  assign w_active        = (r_state == StActive) && !w_ss_rise;
  assign w_enter         = (r_state == StIdle) && w_ss_fall;
  assign w_word_done     = w_active && w_sclk_rise && (r_cnt == CNT_LAST);
  assign w_load          = w_enter || w_word_done;
  assign w_tx_accept     = io_spi.tx_valid && !r_full;
  assign w_shift_in_next = {r_shift_in[WIDTH-2:0], w_mosi_level};

  always_ff @(posedge i_clk) begin
    if (!i_clr_n) begin
      r_state     <= StWaitIdle;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_hold      <= '0;
      r_rx_data   <= '0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_skip_fall <= 1'b0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;

      // A reset mid-frame must not resume that frame: wait for SS_N seen high.
      case (r_state)
        StWaitIdle: begin
          if (w_ss_ready && w_ss_level) r_state <= StIdle;
        end
        StIdle: begin
          if (w_ss_fall) begin
            r_state <= StActive;
            r_busy  <= 1'b1;
          end
        end
        StActive: begin
          if (w_ss_rise) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StWaitIdle;
          r_busy  <= 1'b0;
        end
      endcase

      if (w_abort) begin
        r_cnt       <= '0;
        r_shift_in  <= '0;
        r_shift_out <= '0;
        r_skip_fall <= 1'b0;
      end else if (w_active) begin
        if (w_sclk_rise) begin
          r_shift_in <= w_shift_in_next;
          if (r_cnt == CNT_LAST) begin
            r_cnt      <= '0;
            r_rx_data  <= w_shift_in_next;
            r_rx_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        if (w_sclk_fall) begin
          if (r_skip_fall) r_skip_fall <= 1'b0;
          else             r_shift_out <= {r_shift_out[WIDTH-2:0], 1'b0};
        end
      end

      // The fall after a word-boundary load must keep the fresh MSB on MISO.
      if (w_load) begin
        if (r_full) begin
          r_shift_out <= r_hold;
        end else if (w_tx_accept) begin
          r_shift_out <= io_spi.tx_data;
        end else begin
          r_shift_out <= '0;
          r_underrun  <= 1'b1;
        end
        r_skip_fall <= w_word_done;
      end

      if (w_load) begin
        r_full <= 1'b0;
      end else if (w_tx_accept) begin
        r_full <= 1'b1;
        r_hold <= io_spi.tx_data;
      end
    end
  end

  assign io_spi.miso        = r_busy & r_shift_out[WIDTH-1];
  assign io_spi.tx_ready    = ~r_full;
  assign io_spi.rx_data     = r_rx_data;
  assign io_spi.rx_valid    = r_rx_valid;
  assign io_spi.tx_underrun = r_underrun;
  assign io_spi.busy        = r_busy;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: acts as the SPI mode-0 master and checks MISO words,
// received words and the TX holding buffer against a word-level reference model.
module tb_spi_slave;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned HALF        = 4;  // SCLK half-period in CLK cycles (40 ns)

  logic clk;
  logic clr_n;

  spi_slave_if #(.WIDTH(WIDTH)) bus ();

  spi_slave #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .i_clk   (clk),
    .i_clr_n (clr_n),
    .io_spi  (bus)
  );

  int total   = 0;
  int bad     = 0;
  int und_cnt = 0;
  int m_und   = 0;
  bit m_full  = 1'b0;
  logic [7:0] m_data;
  logic [7:0] rx_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] f_mosi[4];
  bit         f_wr_en[4];
  logic [7:0] f_wr_d[4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
    if (bus.tx_underrun) und_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one-word holding buffer, loads at frame entry and after each word.
  task automatic model_write(input logic [7:0] d);
    if (!m_full) begin
      m_full = 1'b1;
      m_data = d;
    end
  endtask

  task automatic model_load(output logic [7:0] w);
    if (m_full) begin
      w      = m_data;
      m_full = 1'b0;
    end else begin
      w = '0;
      m_und++;
    end
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    model_write(d);
    chk("tx_ready_low", bus.tx_ready, 1'b0);
  endtask

  task automatic run_frame(input int nwords, input int abort_bits, input bit byp_en,
                           input logic [7:0] byp_d);
    logic [7:0] exp_word;
    logic [7:0] got;
    logic [7:0] mask;
    int nb;
    exp_rx.delete();
    rx_q.delete();
    if (byp_en && !m_full) exp_word = byp_d;
    else                   model_load(exp_word);
    bus.ss_n = 1'b0;
    if (byp_en) begin
      repeat (SYNC_STAGES + 1) @(negedge clk);
      bus.tx_data  = byp_d;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      bus.tx_valid = 1'b0;
      chk("byp_busy", bus.busy, 1'b1);
      chk("byp_tx_ready", bus.tx_ready, 1'b1);
    end
    repeat (2 * HALF) @(negedge clk);
    chk("busy_on", bus.busy, 1'b1);
    chk("und_at_entry", und_cnt, m_und);
    for (int w = 0; w < nwords; w++) begin
      nb  = (w == nwords - 1 && abort_bits > 0) ? abort_bits : WIDTH;
      got = '0;
      for (int b = 0; b < nb; b++) begin
        bus.mosi = f_mosi[w][7-b];
        if (b == 3 && f_wr_en[w]) begin
          tx_write(f_wr_d[w]);
          repeat (HALF - 2) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
        got[7-b] = bus.miso;
        bus.sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        bus.sclk = 1'b0;
      end
      if (nb == WIDTH) begin
        chk("miso_word", got, exp_word);
        exp_rx.push_back(f_mosi[w]);
        model_load(exp_word);
      end else begin
        mask = 8'hFF << (WIDTH - nb);
        chk("miso_partial", got & mask, exp_word & mask);
      end
    end
    repeat (HALF) @(negedge clk);
    bus.ss_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    chk("busy_off", bus.busy, 1'b0);
    chk("miso_idle", bus.miso, 1'b0);
    chk("rx_count", rx_q.size(), exp_rx.size());
    for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++) chk("rx_word", rx_q[i], exp_rx[i]);
    if (exp_rx.size() > 0) chk("rx_hold", bus.rx_data, exp_rx[exp_rx.size()-1]);
    chk("underruns", und_cnt, m_und);
    chk("tx_ready", bus.tx_ready, !m_full);
  endtask

  initial begin
    logic [7:0] dummy;
    clr_n        = 1'b0;
    bus.ss_n     = 1'b0;
    bus.sclk     = 1'b0;
    bus.mosi     = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    repeat (4) @(negedge clk);
    chk("rst_miso", bus.miso, 1'b0);
    chk("rst_tx_ready", bus.tx_ready, 1'b1);
    chk("rst_rx_data", bus.rx_data, 8'h00);
    chk("rst_rx_valid", bus.rx_valid, 1'b0);
    chk("rst_underrun", bus.tx_underrun, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);

    // Released with SS_N already low: the frame in progress must be ignored.
    clr_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.mosi = 1'($urandom);
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    chk("busy_stuck_low", bus.busy, 1'b0);
    chk("no_rx_after_rst", rx_q.size(), 0);
    chk("no_und_after_rst", und_cnt, 0);
    bus.ss_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_ss_high", bus.busy, 1'b0);
    model_load(dummy);
    bus.ss_n = 1'b0;
    repeat (2 * HALF) @(negedge clk);
    chk("busy_after_cycle", bus.busy, 1'b1);
    bus.ss_n = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    chk("busy_drop", bus.busy, 1'b0);
    chk("underruns_rst", und_cnt, m_und);

    // Single word: TX A5, RX 3C.
    tx_write(8'hA5);
    f_mosi[0] = 8'h3C; f_wr_en[0] = 1'b0;
    run_frame(1, 0, 1'b0, 8'h00);

    // Back-to-back FF, 01 with 81 preloaded and 7E refilled during word one.
    tx_write(8'h81);
    f_mosi[0] = 8'hFF; f_wr_en[0] = 1'b1; f_wr_d[0] = 8'h7E;
    f_mosi[1] = 8'h01; f_wr_en[1] = 1'b1; f_wr_d[1] = 8'h5A;
    run_frame(2, 0, 1'b0, 8'h00);

    // Empty buffer at entry: MISO all zero, underrun only at entry.
    f_mosi[0] = 8'($urandom); f_wr_en[0] = 1'b1; f_wr_d[0] = 8'($urandom);
    run_frame(1, 0, 1'b0, 8'h00);

    // Abort after 5 bits, then an intact C3 frame.
    tx_write(8'($urandom));
    f_mosi[0] = 8'($urandom); f_wr_en[0] = 1'b0;
    run_frame(1, 5, 1'b0, 8'h00);
    tx_write(8'($urandom));
    f_mosi[0] = 8'hC3; f_wr_en[0] = 1'b1; f_wr_d[0] = 8'($urandom);
    run_frame(1, 0, 1'b0, 8'h00);

    // TX write coinciding with the entry load on an empty buffer.
    f_mosi[0] = 8'($urandom); f_wr_en[0] = 1'b1; f_wr_d[0] = 8'($urandom);
    run_frame(1, 0, 1'b1, 8'h96);

    for (int f = 0; f < 8; f++) begin
      int n;
      n = int'($urandom_range(1, 3));
      if ($urandom_range(0, 3) != 0) tx_write(8'($urandom));
      for (int w = 0; w < 4; w++) begin
        f_mosi[w]  = 8'($urandom);
        f_wr_en[w] = ($urandom_range(0, 2) != 0);
        f_wr_d[w]  = 8'($urandom);
      end
      run_frame(n, 0, ($urandom_range(0, 3) == 0), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
